// File: rtl/branch_predictor.sv
// Purpose : 8-entry direct-mapped BTB with 2-bit saturating direction counters.
// Latency : prediction is combinational from PC_curr; updates commit on the rising clk edge.
// Backpr. : none; one lookup and one update are accepted every cycle, including the same index.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   PC_curr           - fetch PC to predict (index PC[3:1], tag PC[15:4], PC[0] ignored)
//   IF_ID_PC_curr     - PC of the branch being resolved in decode
//   wen_BHT / wen_BTB - counter step / target write strobes
//   actual_taken      - resolved direction
//   actual_target     - resolved target
//   predicted_taken   - hit && counter[1]
//   predicted_target  - stored target when predicted taken, else PC_curr+2
//
// Option: define BP_BYPASS_EN to forward a same-cycle update into the lookup.
module branch_predictor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] PC_curr,
  input  logic [15:0] IF_ID_PC_curr,
  input  logic        wen_BHT,
  input  logic        wen_BTB,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  output logic        predicted_taken,
  output logic [15:0] predicted_target
);

  localparam int N_ENT = 8;

  logic        valid_q  [N_ENT];
  logic [11:0] tag_q    [N_ENT];
  logic [15:0] target_q [N_ENT];
  logic [1:0]  cnt_q    [N_ENT];

  logic        valid_d  [N_ENT];
  logic [11:0] tag_d    [N_ENT];
  logic [15:0] target_d [N_ENT];
  logic [1:0]  cnt_d    [N_ENT];

  logic [2:0]  widx;
  logic [11:0] wtag;
  logic        wr_hit;
  logic        alloc;

  logic [2:0]  ridx;
  logic        lk_valid;
  logic [11:0] lk_tag;
  logic [15:0] lk_target;
  logic [1:0]  lk_cnt;
  logic        hit;
  logic [15:0] pc_plus2;

  // Bit 0 of a halfword-aligned PC carries no information.
  logic unused_if_id_lsb;
  assign unused_if_id_lsb = IF_ID_PC_curr[0];

  assign widx   = IF_ID_PC_curr[3:1];
  assign wtag   = IF_ID_PC_curr[15:4];
  assign wr_hit = valid_q[widx] && (tag_q[widx] == wtag);
  // A target write into an empty or foreign entry replaces it and reseeds the counter.
  assign alloc  = wen_BTB && !wr_hit;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;

    if (wen_BTB) begin
      valid_d[widx]  = 1'b1;
      tag_d[widx]    = wtag;
      target_d[widx] = actual_target;
    end

    // Counters are untagged: a plain step applies even when the tag differs.
    // Allocation takes priority over a same-cycle step.
    if (alloc) begin
      cnt_d[widx] = actual_taken ? 2'b10 : 2'b01;
    end else if (wen_BHT) begin
      if (actual_taken) begin
        if (cnt_q[widx] != 2'b11) cnt_d[widx] = cnt_q[widx] + 2'd1;
      end else begin
        if (cnt_q[widx] != 2'b00) cnt_d[widx] = cnt_q[widx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= 12'h000;
        target_q[i] <= 16'h0000;
        cnt_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ridx     = PC_curr[3:1];
  assign pc_plus2 = PC_curr + 16'd2;

`ifdef BP_BYPASS_EN
  // Next-state arrays differ from the registers only at the written index, so
  // reading them forwards a same-index update. Held off while in reset, where
  // the update will be discarded anyway.
  always_comb begin
    if (rst_n) begin
      lk_valid  = valid_d[ridx];
      lk_tag    = tag_d[ridx];
      lk_target = target_d[ridx];
      lk_cnt    = cnt_d[ridx];
    end else begin
      lk_valid  = valid_q[ridx];
      lk_tag    = tag_q[ridx];
      lk_target = target_q[ridx];
      lk_cnt    = cnt_q[ridx];
    end
  end
`else
  always_comb begin
    lk_valid  = valid_q[ridx];
    lk_tag    = tag_q[ridx];
    lk_target = target_q[ridx];
    lk_cnt    = cnt_q[ridx];
  end
`endif

  assign hit              = lk_valid && (lk_tag == PC_curr[15:4]);
  assign predicted_taken  = hit && lk_cnt[1];
  assign predicted_target = predicted_taken ? lk_target : pc_plus2;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port PC_curr, input, 16 bits: fetch-stage PC to predict.
REQ-004 SHALL have port IF_ID_PC_curr, input, 16 bits: PC of the branch being resolved in decode.
REQ-005 SHALL have port wen_BHT, input, 1 bit: counter update strobe from the control unit.
REQ-006 SHALL have port wen_BTB, input, 1 bit: target update strobe from the control unit.
REQ-007 SHALL have port actual_taken, input, 1 bit: resolved branch direction.
REQ-008 SHALL have port actual_target, input, 16 bits: resolved branch target.
REQ-009 SHALL have port predicted_taken, output, 1 bit: direction prediction for PC_curr.
REQ-010 SHALL have port predicted_target, output, 16 bits: next-PC prediction for PC_curr.

Function
REQ-011 SHALL hold 8 direct-mapped entries, each with: valid (1 bit), tag (12 bits), target (16 bits) and counter (2-bit saturating).
REQ-012 SHALL index entries with PC[3:1] and tag them with PC[15:4]; PC[0] is ignored.
REQ-013 SHALL compute the prediction combinationally from PC_curr in the same cycle: hit = valid && tag match.
REQ-014 SHALL drive predicted_taken = hit && counter[1].
REQ-015 SHALL drive predicted_target = stored target when predicted_taken=1, else PC_curr+2 (16-bit, wraps 16'hFFFE->16'h0000).
REQ-016 SHALL, on a clock edge with wen_BHT=1, move the counter at IF_ID_PC_curr[3:1] one step: +1 if actual_taken, -1 otherwise.
REQ-017 SHALL saturate counters at 2'b11 and 2'b00; the counter is untagged and updates even on a tag mismatch.
REQ-018 SHALL, on a clock edge with wen_BTB=1, write actual_target and tag IF_ID_PC_curr[15:4] and set valid=1.
REQ-019 SHALL, when wen_BTB=1 and the entry was invalid or tag-mismatched (allocation), set the counter to 2'b10 if actual_taken else 2'b01; this overrides any wen_BHT step in the same cycle.
REQ-020 SHALL, when wen_BTB=1 hits an existing valid entry with the same tag, apply the wen_BHT step normally and leave valid set.
REQ-021 SHALL accept simultaneous updates (IF_ID_PC_curr index) and lookups (PC_curr index), including the same index; without REQ-027 the lookup returns pre-edge contents.
REQ-022 SHALL ignore actual_taken and actual_target when both wen_BHT and wen_BTB are 0; no state changes.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously clear all valid bits, set all counters to 2'b01, and set all tags and targets to 0.
REQ-024 SHALL, during and after reset with no update, drive predicted_taken=0 and predicted_target=PC_curr+2.
REQ-025 SHALL discard any update whose clock edge coincides with rst_n=0; an update in progress when reset asserts mid-operation is lost.
REQ-026 SHALL resume accepting updates on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when macro BP_BYPASS_EN is defined, forward a same-cycle write when PC_curr[3:1]==IF_ID_PC_curr[3:1]: prediction uses the post-update valid, tag, target and counter values, computed combinationally.
REQ-028 SHALL, when BP_BYPASS_EN is undefined, include no forwarding path; the prediction reflects registered state only.

Verification
REQ-029 SHALL cover post-reset lookup: PC_curr=16'h0040 -> predicted_taken=0, predicted_target=16'h0042; PC_curr=16'hFFFE -> predicted_target=16'h0000.
REQ-030 SHALL cover allocation: wen_BTB=1, actual_taken=1, IF_ID_PC_curr=16'h0024, actual_target=16'h0100, one edge; then PC_curr=16'h0024 -> predicted_taken=1, predicted_target=16'h0100.
REQ-031 SHALL cover saturation: four wen_BHT edges with actual_taken=0 on that entry -> counter 2'b00, predicted_taken=0, predicted_target=16'h0026; a further decrement leaves 2'b00; two increments give predicted_taken=1.
REQ-032 SHALL cover aliasing: allocate 16'h0024, then look up PC_curr=16'h0124 (same index, different tag) -> predicted_taken=0, predicted_target=16'h0126.
REQ-033 SHALL cover same-index read/write: lookup at 16'h0024 during an allocation edge -> old value without BP_BYPASS_EN, new value with it.
REQ-034 SHALL cover reset mid-operation: assert rst_n=0 between two update edges -> all entries invalid and the second update discarded.
